// File: rtl/memory_responder_if.sv
// memory_responder_if
//   Bundles the request-unit side and the RAM side of the memory responder.
//   slave  : view taken by memory_responder (receives requests, drives the RAM).
//   master : view taken by whatever drives requests and models the RAM.
// Signals
//   iREN/iaddr            instruction fetch request, held until ihit
//   dREN/dWEN/daddr/dstore data read/write request, held until dhit
//   ihit/iload            fetch completion pulse and instruction word
//   dhit/dload            data completion pulse and read word
//   merr                  one-cycle pulse on RAM ERROR or timeout
//   ramREN/ramWEN/ramaddr/ramstore  RAM command
//   ramload/ramstate      RAM response (FREE=00 BUSY=01 ACCESS=10 ERROR=11)
interface memory_responder_if #(
  parameter int unsigned WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              merr;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder
//   Arbitrates the instruction fetch port and the data port onto a single-port
//   RAM. Data requests win over fetches; every access returns to IDLE for at
//   least one cycle, so a held fetch is served after each data access.
// Ports
//   CLK   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   memory_responder_if.slave: request ports, completion pulses, RAM port
// Parameters
//   WORD_W   data/address width
//   TMO_MAX  cycles in an access state without ACCESS before abort (merr)
module memory_responder #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TMO_MAX = 15
) (
  input  logic                CLK,
  input  logic                nRST,
  memory_responder_if.slave   bus
);

  localparam int unsigned TMO_W = $clog2(TMO_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  state_t           state, next_state;
  logic [TMO_W-1:0] tmo, tmo_next;
  ramstate_t        rs;

  logic              ihit_c, dhit_c, merr_c, ren_c, wen_c;
  logic [WORD_W-1:0] iload_c, dload_c, addr_c, store_c;

  assign rs = ramstate_t'(bus.ramstate);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      state <= next_state;
      tmo   <= tmo_next;
    end
  end

  always_comb begin
    next_state = state;
    tmo_next   = tmo;
    ihit_c     = 1'b0;
    dhit_c     = 1'b0;
    merr_c     = 1'b0;
    ren_c      = 1'b0;
    wen_c      = 1'b0;
    iload_c    = '0;
    dload_c    = '0;
    addr_c     = '0;
    store_c    = '0;

    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          next_state = DACC;
        end else if (bus.iREN) begin
          next_state = IACC;
        end
      end

      DACC: begin
        if (!(bus.dREN || bus.dWEN)) begin
          // Requester withdrew: drop the RAM command in this same cycle.
          next_state = IDLE;
        end else begin
          addr_c  = bus.daddr;
          store_c = bus.dstore;
          // Write takes precedence when both enables are held.
          if (bus.dWEN) begin
            wen_c = 1'b1;
          end else begin
            ren_c = 1'b1;
          end
          case (rs)
            ACCESS: begin
              dhit_c     = 1'b1;
              dload_c    = bus.dWEN ? '0 : bus.ramload;
              next_state = IDLE;
            end
            ERROR: begin
              merr_c     = 1'b1;
              next_state = IDLE;
            end
            default: begin
              if (tmo == TMO_W'(TMO_MAX)) begin
                merr_c     = 1'b1;
                next_state = IDLE;
              end else begin
                tmo_next = tmo + TMO_W'(1);
              end
            end
          endcase
        end
      end

      IACC: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          ren_c  = 1'b1;
          addr_c = bus.iaddr;
          case (rs)
            ACCESS: begin
              ihit_c     = 1'b1;
              iload_c    = bus.ramload;
              next_state = IDLE;
            end
            ERROR: begin
              merr_c     = 1'b1;
              next_state = IDLE;
            end
            default: begin
              if (tmo == TMO_W'(TMO_MAX)) begin
                merr_c     = 1'b1;
                next_state = IDLE;
              end else begin
                tmo_next = tmo + TMO_W'(1);
              end
            end
          endcase
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    if (next_state == IDLE) begin
      tmo_next = '0;
    end

    // Outputs follow nRST combinationally so they vanish the instant reset asserts.
    if (!nRST) begin
      ihit_c  = 1'b0;
      dhit_c  = 1'b0;
      merr_c  = 1'b0;
      ren_c   = 1'b0;
      wen_c   = 1'b0;
      iload_c = '0;
      dload_c = '0;
      addr_c  = '0;
      store_c = '0;
    end
  end

  assign bus.ihit     = ihit_c;
  assign bus.iload    = iload_c;
  assign bus.dhit     = dhit_c;
  assign bus.dload    = dload_c;
  assign bus.merr     = merr_c;
  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;
  assign bus.ramaddr  = addr_c;
  assign bus.ramstore = store_c;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
//   Directed bench for memory_responder. Inputs change 1ns after the rising
//   edge; outputs are sampled on the falling edge.
//   Flag word packing: {ihit,dhit,merr,ramREN,ramWEN} -> 16/8/4/2/1.
module tb_memory_responder;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  memory_responder_if #(.WORD_W(32)) bus ();

  memory_responder #(
    .WORD_W  (32),
    .TMO_MAX (15)
  ) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, bus.ihit, bus.dhit, bus.merr, bus.ramREN, bus.ramWEN};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flg"},   flags(),      32'd0);
    chk({tag, "_iload"}, bus.iload,    32'd0);
    chk({tag, "_dload"}, bus.dload,    32'd0);
    chk({tag, "_addr"},  bus.ramaddr,  32'd0);
    chk({tag, "_store"}, bus.ramstore, 32'd0);
  endtask

  // Fetch with the RAM stuck in one non-ACCESS state: merr on 16th access cycle.
  task automatic run_timeout(input string tag, input logic [1:0] stuck);
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = stuck;
    settle();
    chk({tag, "_c0"}, flags(), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      settle();
      chk($sformatf("%s_c%0d", tag, c), flags(), (c == 16) ? 32'd6 : 32'd2);
    end
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'b00;
    settle();
    chk({tag, "_after"}, flags(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with every request asserted.
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h1234; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    bus.daddr = 32'h5678; bus.dstore = 32'h9ABC; bus.ramload = 32'hFFFF0000;
    bus.ramstate = 2'b10;
    #3;
    chk_idle("rst");
    tick();
    settle();
    chk_idle("rst2");
    tick();
    nRST = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = 2'b00;
    settle();
    chk_idle("idle0");
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      chk($sformatf("idle%0d", c + 1), flags(), 32'd0);
    end

    // Fetch: two BUSY cycles then ACCESS.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = 2'b01;
    settle();
    chk("fetch_c0", flags(), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin
        bus.ramstate = 2'b10; bus.ramload = 32'h8C220004;
      end
      settle();
      chk($sformatf("fetch_addr%0d", c), bus.ramaddr, 32'h100);
      chk($sformatf("fetch_flg%0d", c), flags(), (c == 3) ? 32'd18 : 32'd2);
      if (c == 3) chk("fetch_iload", bus.iload, 32'h8C220004);
    end
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'b00;
    settle();
    chk_idle("fetch_after");

    // Tie between fetch and data read: data first.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.ramstate = 2'b10; bus.ramload = 32'h11112222;
    settle();
    chk("tie_c0", flags(), 32'd0);
    tick();
    settle();
    chk("tie_dflg", flags(), 32'd10);
    chk("tie_dload", bus.dload, 32'h11112222);
    chk("tie_daddr", bus.ramaddr, 32'h200);
    tick();
    bus.dREN = 1'b0; bus.ramload = 32'h33334444;
    settle();
    chk("tie_gap", flags(), 32'd0);
    tick();
    settle();
    chk("tie_iflg", flags(), 32'd18);
    chk("tie_iload", bus.iload, 32'h33334444);
    chk("tie_iaddr", bus.ramaddr, 32'h300);
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'b00;
    settle();
    chk("tie_after", flags(), 32'd0);

    // Write with dREN also held: write wins.
    tick();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'hDEADBEEF;
    bus.ramstate = 2'b01;
    settle();
    tick();
    settle();
    chk("wr_flg", flags(), 32'd1);
    chk("wr_store", bus.ramstore, 32'hDEADBEEF);
    chk("wr_addr", bus.ramaddr, 32'h40);
    tick();
    bus.ramstate = 2'b10; bus.ramload = 32'h55555555;
    settle();
    chk("wr_hit", flags(), 32'd9);
    chk("wr_dload", bus.dload, 32'd0);
    tick();
    bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.dstore = '0; bus.daddr = '0;
    bus.ramstate = 2'b00;
    settle();
    chk_idle("wr_after");

    // Timeout, twice to confirm the counter restarts; then RAM ERROR.
    run_timeout("tmo_busy", 2'b01);
    run_timeout("tmo_free", 2'b00);
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = 2'b00;
    settle();
    tick();
    bus.ramstate = 2'b11;
    settle();
    chk("err_flg", flags(), 32'd6);
    tick();
    bus.dREN = 1'b0; bus.ramstate = 2'b00;
    settle();
    chk("err_after", flags(), 32'd0);

    // Fetch withdrawn mid-access.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h600; bus.ramstate = 2'b01;
    settle();
    tick();
    settle();
    chk("ab_acc", flags(), 32'd2);
    tick();
    bus.iREN = 1'b0; bus.ramstate = 2'b10;
    settle();
    chk("ab_drop", flags(), 32'd0);
    chk("ab_addr", bus.ramaddr, 32'd0);
    tick();
    settle();
    chk("ab_after", flags(), 32'd0);

    // Reset asserted mid data access.
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h700; bus.ramstate = 2'b01;
    settle();
    tick();
    settle();
    chk("rm_acc", flags(), 32'd2);
    chk("rm_addr", bus.ramaddr, 32'h700);
    #1;
    nRST = 1'b0;
    bus.ramstate = 2'b10; bus.ramload = 32'h77778888;
    #1;
    chk_idle("rm_async");
    tick();
    nRST = 1'b1;
    settle();
    chk("rm_rel_idle", flags(), 32'd0);
    tick();
    settle();
    chk("rm_reacc", flags(), 32'd10);
    chk("rm_dload", bus.dload, 32'h77778888);
    tick();
    bus.dREN = 1'b0; bus.ramstate = 2'b00;
    settle();
    chk_idle("rm_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
